// File: rtl/uart_boot_loader.sv
// Framed UART boot loader: receives SYNC, 16-bit word count, payload and an 8-bit sum,
// writes whole little-endian words to memory and holds the CPU in reset while loading.
module uart_boot_loader #(
    parameter int unsigned        DATA_W         = 32,
    parameter int unsigned        ADDR_W         = 32,
    parameter int unsigned        MAX_WORDS      = 512,
    parameter logic [ADDR_W-1:0]  BASE_ADDR      = '0,
    parameter logic [7:0]         SYNC_BYTE      = 8'hA5,
    parameter int unsigned        TIMEOUT_CYCLES = 120000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_wa,
    output logic [DATA_W-1:0] mem_wd,
    output logic [2:0]        mem_funct3,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [15:0]       words_loaded
);
    localparam int unsigned BPW  = DATA_W / 8;
    localparam int unsigned BI_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, PAYLOAD, CSUM, DONE, ERR} state_t;

    state_t            state, state_next;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [15:0]       len_in;
    logic [7:0]        sum;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] word_next;
    logic [BI_W-1:0]   byte_idx;
    logic [TO_W-1:0]   tcnt;
    logic              timed;
    logic              expire;
    logic              start;
    logic              word_done;

    assign len_in     = {rx_data, len_lo};
    assign word_next  = (shreg >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
    assign timed      = (state == LEN0) || (state == LEN1) || (state == PAYLOAD) || (state == CSUM);
    assign expire     = timed && !rx_valid && (tcnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign mem_funct3 = 3'b010;
    assign load_done  = (state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        word_done  = 1'b0;
        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE) begin
                    start      = 1'b1;
                    state_next = LEN0;
                end
            end
            LEN0: if (rx_valid) state_next = LEN1;
            LEN1: begin
                if (rx_valid) begin
                    if (len_in == 16'd0 || len_in > 16'(MAX_WORDS)) state_next = ERR;
                    else                                            state_next = PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (rx_valid && byte_idx == BI_W'(BPW - 1)) begin
                    word_done = 1'b1;
                    if (words_loaded + 16'd1 == len) state_next = CSUM;
                end
            end
            CSUM: if (rx_valid) state_next = (rx_data == sum) ? DONE : ERR;
            DONE: state_next = IDLE;
            ERR:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // expire only fires without rx_valid, so a byte on the expiry cycle wins
        if (expire) state_next = ERR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo       <= '0;
            len          <= '0;
            sum          <= '0;
            shreg        <= '0;
            byte_idx     <= '0;
            tcnt         <= '0;
            mem_wen      <= 1'b0;
            mem_wa       <= '0;
            mem_wd       <= '0;
            cpu_hold     <= 1'b0;
            load_error   <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_wen <= 1'b0;

            if (timed && !rx_valid) tcnt <= tcnt + TO_W'(1);
            else                    tcnt <= '0;

            if (start) begin
                sum          <= '0;
                byte_idx     <= '0;
                words_loaded <= '0;
                load_error   <= 1'b0;
                cpu_hold     <= 1'b1;
            end

            if (state == LEN0 && rx_valid) len_lo <= rx_data;
            if (state == LEN1 && rx_valid) len    <= len_in;

            if (state == PAYLOAD && rx_valid) begin
                sum      <= sum + rx_data;
                shreg    <= word_next;
                byte_idx <= word_done ? '0 : byte_idx + BI_W'(1);
            end

            // words_loaded advances together with the write it describes
            if (word_done) begin
                mem_wen <= 1'b1;
                mem_wd  <= word_next;
                mem_wa  <= BASE_ADDR + ADDR_W'(words_loaded) * ADDR_W'(BPW);
                if (words_loaded < 16'(MAX_WORDS)) words_loaded <= words_loaded + 16'd1;
            end

            if (state == DONE) cpu_hold   <= 1'b0;
            if (state == ERR)  load_error <= 1'b1;
        end
    end
endmodule
